hybrid_scheduler: RTL and testbench
===================================

# hybrid_scheduler

Sequencer and round-robin arbiter that shares one `Hybrid` function-evaluation core (reciprocal / sqrt / inverse-sqrt interpolator) among `N_REQ` requesters. It accepts one operation at a time over valid/ready, drives the core's `din`, `FUNCTION` and `CE` for exactly the core's iteration latency, and captures the rounded result. It returns the result with requester ID on a single response channel that supports backpressure. It sits between the client blocks and the `Hybrid` instance; the core shares `CLK` and `nRST` with this block.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WL`, 24, operand/result word length (matches core `WL`)
- `CORE_LAT`, 2, CE cycles from launch until core `dout` holds the result (core `p`+1)
- `IDW`, $clog2(N_REQ), requester ID width (derived, not overridden)

- `CLK`  in  1  clock
- `nRST`  in  1  reset, synchronous, active-low
- `req_valid`  in  N_REQ  per-requester request valid
- `req_ready`  out  N_REQ  per-requester accept, one-hot or zero
- `req_din`  in  N_REQ*WL  operands, requester i at [i*WL +: WL]
- `req_func`  in  N_REQ*2  function codes: 00 rec, 01 sqrt, 10 isqt, 11 illegal
- `core_din`  out  WL  operand to core
- `core_func`  out  2  FUNCTION to core
- `core_ce`  out  1  core clock enable
- `core_dout`  in  WL  core result
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  IDW  originating requester
- `rsp_data`  out  WL  result (0 on error)
- `rsp_err`  out  1  illegal function code
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, RUN, CAP, RESP.
- IDLE
  - The arbiter picks the winner among `req_valid`; `req_ready[winner]`=1 combinationally, all other ready bits 0.
  - On handshake, latch din/func/id and set `last_grant`=id.
  - func≠11 → RUN, cnt=0. func=11 → RESP with `rsp_err`=1, `rsp_data`=0; the core is not touched.
- RUN
  - `core_ce`=1; `core_din`/`core_func` are driven from the latched registers and held stable.
  - cnt increments each cycle; after the cycle with cnt==CORE_LAT-1 → CAP.
- CAP
  - `core_ce`=0; register `core_dout` into `rsp_data`, `rsp_err`=0 → RESP.
- RESP
  - `rsp_valid`=1; `rsp_id`, `rsp_data` and `rsp_err` are held stable until `rsp_ready`.
  - On the handshake edge → IDLE.
  - No new request is accepted while in RESP (single outstanding op).
- Round-robin: priority starts at `last_grant`+1 mod N_REQ. Reset value `last_grant`=N_REQ-1, so requester 0 has first priority.
- `core_ce` is asserted for exactly CORE_LAT cycles per legal op. This leaves the core's internal iteration pointer at 0 between ops, and this block relies on it.
- `req_ready` is never asserted outside IDLE; requesters may hold or drop `req_valid` freely before the handshake.

## Timing
- Reset values:
  - state=IDLE, `req_ready`=0, `core_ce`=0, `core_din`=0, `core_func`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, cnt=0.
- Legal op, `rsp_ready` held high:
  - accept at edge T; `core_ce` high T+1..T+CORE_LAT; CAP at T+CORE_LAT+1.
  - `rsp_valid` from T+CORE_LAT+2; back in IDLE at T+CORE_LAT+3.
  - Throughput: one op per CORE_LAT+3 cycles.
- Illegal op: accept at T; `rsp_valid` at T+1.
- Back-to-back: the next request can be accepted in the first IDLE cycle after the response handshake.
- Reset mid-operation (any state): the op is abandoned, no response is issued, and `core_ce` drops in the same cycle. The core resets concurrently via the shared `nRST`.
- `rsp_ready` low: RESP persists indefinitely; `core_ce` stays 0.

## Structure
- Package `hybrid_sched_pkg`:
  - function codes FUNC_REC=2'b00, FUNC_SQRT=2'b01, FUNC_ISQT=2'b10, FUNC_ILL=2'b11.
  - FSM state encoding.
- Sub-module `rr_arbiter` (params N; ports req, last, grant one-hot, id, any): purely combinational rotate-priority encoder.
- Top: FSM, latency counter, operand/response registers, core port drive.

## Test plan
- Single legal op: req 2 sends din=24'h400000, func=00, `rsp_ready`=1 → `core_ce` high exactly 2 cycles; `rsp_valid` 4 cycles after accept with `rsp_id`=2, `rsp_data` equal to `core_dout` sampled in CAP, `rsp_err`=0.
- Round-robin fairness: all 4 `req_valid` held high, func=01 → grant order 0,1,2,3,0,…; no `req_ready` while `busy`=1.
- Illegal func: req 1 sends func=11 → `rsp_valid` one cycle after accept, `rsp_err`=1, `rsp_data`=0, `core_ce` never asserted.
- Backpressure: `rsp_ready`=0 for 10 cycles after `rsp_valid` → outputs stable, state RESP, `core_ce`=0, req 3 pending stays unaccepted until 1 cycle after the `rsp_ready` handshake.
- Reset mid-RUN: deassert `nRST` at cnt=1 → next edge all outputs at reset values; no response for the abandoned op; subsequent op completes normally.
- Operand stability: change `req_din` after the handshake → `core_din` keeps the latched value for all CORE_LAT CE cycles.

Source files
------------

// File: rtl/hybrid_sched_pkg.sv
// Shared definitions for the Hybrid core scheduler: function codes and FSM encoding.
package hybrid_sched_pkg;

  localparam logic [1:0] FUNC_REC  = 2'b00;
  localparam logic [1:0] FUNC_SQRT = 2'b01;
  localparam logic [1:0] FUNC_ISQT = 2'b10;
  localparam logic [1:0] FUNC_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_CAP  = 2'b10,
    ST_RESP = 2'b11
  } sched_state_t;

  function automatic logic func_is_legal(input logic [1:0] f);
    return (f == FUNC_REC) || (f == FUNC_SQRT) || (f == FUNC_ISQT);
  endfunction

endpackage

// File: rtl/hybrid_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: priority starts one above the last granted requester.
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] id,
  output logic           any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  int             w_off;
  int             w_win;

  always_comb begin
    // Rotate so bit 0 is the requester just above 'last'; lowest set bit wins.
    w_dbl = {req, req} >> (int'(last) + 1);
    w_rot = w_dbl[N-1:0];
    w_off = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = j;
    end
    w_win = int'(last) + 1 + w_off;
    if (w_win >= N) w_win = w_win - N;
    any   = |req;
    grant = '0;
    id    = '0;
    if (any) begin
      grant = {{(N-1){1'b0}}, 1'b1} << w_win;
      id    = IDW'(w_win);
    end
  end

endmodule

// File: rtl/hybrid_scheduler.sv
// Shares one Hybrid function core among N_REQ requesters: arbitrate, run the core
// for exactly CORE_LAT enabled cycles, and return the captured result with its ID.
module hybrid_scheduler
  import hybrid_sched_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int WL       = 24,
  parameter  int CORE_LAT = 2,
  localparam int IDW      = $clog2(N_REQ)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*WL-1:0] req_din,
  input  logic [N_REQ*2-1:0] req_func,
  output logic [WL-1:0]      core_din,
  output logic [1:0]         core_func,
  output logic               core_ce,
  input  logic [WL-1:0]      core_dout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [WL-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  localparam int              CNTW     = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CORE_LAT - 1);

  sched_state_t    r_state;
  sched_state_t    w_next;
  logic [CNTW-1:0] r_cnt;
  logic [WL-1:0]   r_din;
  logic [1:0]      r_func;
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  r_id;
  logic [WL-1:0]   r_data;
  logic            r_err;

  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_win_id;
  logic             w_any;
  logic [WL-1:0]    w_sel_din;
  logic [1:0]       w_sel_func;
  logic             w_sel_legal;
  logic             w_accept;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .last  (r_last),
    .grant (w_grant),
    .id    (w_win_id),
    .any   (w_any)
  );

  // One-hot mux of the winning requester's operand and function code.
  always_comb begin
    w_sel_din  = '0;
    w_sel_func = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_din  = w_sel_din  | req_din[i*WL +: WL];
        w_sel_func = w_sel_func | req_func[i*2 +: 2];
      end
    end
  end

  assign w_sel_legal = func_is_legal(w_sel_func);
  assign w_accept    = (r_state == ST_IDLE) && w_any;

  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Handshake outputs are gated by nRST so a reset abandons the op in the same cycle.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    core_ce   = 1'b0;
    rsp_valid = 1'b0;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        req_ready = nRST ? w_grant : '0;
        if (w_any) w_next = w_sel_legal ? ST_RUN : ST_RESP;
      end
      ST_RUN: begin
        core_ce = nRST;
        if (r_cnt == CNT_LAST) w_next = ST_CAP;
      end
      ST_CAP: w_next = ST_RESP;
      ST_RESP: begin
        rsp_valid = nRST;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_cnt  <= '0;
      r_din  <= '0;
      r_func <= '0;
      r_last <= IDW'(N_REQ - 1);
      r_id   <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id   <= w_win_id;
        r_last <= w_win_id;
        r_cnt  <= '0;
        if (w_sel_legal) begin
          r_din  <= w_sel_din;
          r_func <= w_sel_func;
        end else begin
          // Illegal code: answer immediately, leave the core inputs untouched.
          r_err  <= 1'b1;
          r_data <= '0;
        end
      end
      if (r_state == ST_RUN) begin
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      end
      if (r_state == ST_CAP) begin
        r_data <= core_dout;
        r_err  <= 1'b0;
      end
    end
  end

  assign core_din  = r_din;
  assign core_func = r_func;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_hybrid_scheduler.sv
// Scoreboard bench for hybrid_scheduler with a behavioural two-stage core model.
module tb_hybrid_scheduler;
  import hybrid_sched_pkg::*;

  localparam int N   = 4;
  localparam int WL  = 24;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*WL-1:0]   req_din;
  logic [N*2-1:0]    req_func;
  logic [WL-1:0]     core_din;
  logic [1:0]        core_func;
  logic              core_ce;
  logic [WL-1:0]     core_dout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [WL-1:0]     rsp_data;
  logic              rsp_err;
  logic              busy;

  hybrid_scheduler #(.N_REQ(N), .WL(WL), .CORE_LAT(LAT)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din(req_din), .req_func(req_func),
    .core_din(core_din), .core_func(core_func), .core_ce(core_ce),
    .core_dout(core_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Arbitrary but operand/function sensitive stand-in for the interpolator.
  function automatic logic [WL-1:0] core_fn(input logic [WL-1:0] d, input logic [1:0] f);
    return {d[WL-2:0], d[WL-1]} ^ {f, 22'h0} ^ (WL'(f) * 24'h010203) ^ 24'h00A5C3;
  endfunction

  // Core: result appears in dout after two enabled cycles with a stable operand.
  logic [WL-1:0] core_s1;
  always @(posedge CLK) begin
    if (!nRST) begin
      core_s1   <= '0;
      core_dout <= '0;
    end else if (core_ce) begin
      core_s1   <= core_fn(core_din, core_func);
      core_dout <= core_s1;
    end
  end

  typedef struct {
    logic [IDW-1:0] id;
    logic [WL-1:0]  din;
    logic [1:0]     func;
    logic [WL-1:0]  data;
    logic           err;
    int             acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
  endfunction

  function automatic logic [N-1:0] rr_model(input logic [N-1:0] v, input int last);
    logic [N-1:0] g;
    g = '0;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Reference model state: one outstanding op at most.
  int m_last   = N - 1;
  bit m_out    = 1'b0;
  bit acc_flag = 1'b0;
  int acc_id   = 0;

  task automatic sample_and_model();
    logic [N-1:0] exp_rdy;
    exp_t item;
    acc_flag = 1'b0;
    if (!nRST) begin
      chk("ready_in_reset", req_ready, 0);
      chk("ce_in_reset", core_ce, 0);
      chk("rsp_valid_in_reset", rsp_valid, 0);
      sb.delete();
      m_out  = 1'b0;
      m_last = N - 1;
      return;
    end
    exp_rdy = m_out ? '0 : rr_model(req_valid, m_last);
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_out);
    if (exp_rdy != '0) begin
      for (int i = 0; i < N; i++) if (exp_rdy[i]) acc_id = i;
      item.id   = IDW'(acc_id);
      item.din  = req_din[acc_id*WL +: WL];
      item.func = req_func[acc_id*2 +: 2];
      item.err  = (item.func == 2'b11);
      item.data = item.err ? '0 : core_fn(item.din, item.func);
      item.acc  = cyc;
      sb.push_back(item);
      m_out    = 1'b1;
      m_last   = acc_id;
      acc_flag = 1'b1;
    end else if (m_out && rsp_valid && rsp_ready) begin
      m_out = 1'b0;
    end
  endtask

  // Called right after a falling edge with inputs already applied.
  task automatic step();
    #4;
    sample_and_model();
    @(negedge CLK);
  endtask

  task automatic set_req(input int i, input bit v, input logic [WL-1:0] d, input logic [1:0] f);
    req_valid[i]         = v;
    req_din[i*WL +: WL]  = d;
    req_func[i*2 +: 2]   = f;
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_core_ce", core_ce, 0);
    chk("rst_core_din", core_din, 0);
    chk("rst_core_func", core_func, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic wait_accept(input string name);
    int k;
    k = 0;
    step();
    while (!acc_flag && k < 20) begin
      step();
      k++;
    end
    if (!acc_flag) fail_now(name);
  endtask

  task automatic wait_done(input int max);
    int k;
    k = 0;
    while (m_out && k < max) begin
      step();
      k++;
    end
    if (m_out) fail_now("response_timeout");
  endtask

  task automatic send_one(input int i, input logic [WL-1:0] d, input logic [1:0] f);
    set_req(i, 1'b1, d, f);
    wait_accept("accept_timeout");
    set_req(i, 1'b0, WL'($urandom()), 2'($urandom()));
    wait_done(20);
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  bit             in_rsp = 1'b0;
  int             ce_cnt = 0;
  logic [IDW-1:0] h_id;
  logic [WL-1:0]  h_data;
  logic           h_err;

  always begin
    @(negedge CLK);
    #2;
    if (!nRST) begin
      in_rsp = 1'b0;
      ce_cnt = 0;
    end else begin
      if (core_ce) begin
        ce_cnt++;
        if (sb.size() == 0) fail_now("ce_without_op");
        else begin
          chk("core_din_stable", core_din, sb[0].din);
          chk("core_func_stable", core_func, sb[0].func);
        end
      end
      if (rsp_valid) begin
        if (sb.size() == 0) fail_now("spurious_rsp");
        else begin
          if (!in_rsp) begin
            chk("rsp_id", rsp_id, sb[0].id);
            chk("rsp_data", rsp_data, sb[0].data);
            chk("rsp_err", rsp_err, sb[0].err);
            chk("rsp_latency", cyc - sb[0].acc, sb[0].err ? 1 : LAT + 2);
            chk("ce_cycles", ce_cnt, sb[0].err ? 0 : LAT);
            h_id   = rsp_id;
            h_data = rsp_data;
            h_err  = rsp_err;
            in_rsp = 1'b1;
          end else begin
            chk("hold_id", rsp_id, h_id);
            chk("hold_data", rsp_data, h_data);
            chk("hold_err", rsp_err, h_err);
            chk("ce_in_resp", core_ce, 0);
          end
          if (rsp_ready) begin
            void'(sb.pop_front());
            in_rsp = 1'b0;
            ce_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_din   = '0;
    req_func  = '0;
    rsp_ready = 1'b1;
    nRST      = 1'b0;
    @(negedge CLK);
    repeat (3) step();
    check_reset_vals();
    nRST = 1'b1;

    // Single legal op from requester 2, operand changed right after acceptance.
    send_one(2, 24'h400000, FUNC_REC);

    // Illegal function from requester 1.
    send_one(1, WL'($urandom()), FUNC_ILL);

    // Fairness: everyone requesting sqrt continuously.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, WL'($urandom()), FUNC_SQRT);
    for (int c = 0; c < 30; c++) begin
      step();
      if (acc_flag) set_req(acc_id, 1'b1, WL'($urandom()), FUNC_SQRT);
    end
    req_valid = '0;
    wait_done(20);

    // Backpressure with requester 3 waiting behind requester 0.
    set_req(0, 1'b1, WL'($urandom()), FUNC_ISQT);
    wait_accept("bp_accept_timeout");
    set_req(0, 1'b0, '0, '0);
    rsp_ready = 1'b0;
    set_req(3, 1'b1, WL'($urandom()), FUNC_REC);
    repeat (LAT + 2 + 10) step();
    rsp_ready = 1'b1;
    wait_accept("bp_pending_timeout");
    chk("bp_pending_id", acc_id, 3);
    set_req(3, 1'b0, '0, '0);
    wait_done(20);

    // Reset while the core is in its second enabled cycle.
    set_req(1, 1'b1, WL'($urandom()), FUNC_SQRT);
    wait_accept("rst_accept_timeout");
    set_req(1, 1'b0, '0, '0);
    step();
    nRST = 1'b0;
    step();
    check_reset_vals();
    nRST = 1'b1;
    step();
    send_one(2, WL'($urandom()), FUNC_ISQT);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        logic [1:0] f;
        f = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        set_req(i, ($urandom_range(0, 99) < 40), WL'($urandom()), f);
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_done(40);
    repeat (3) step();
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
